// File: rtl/reg_write_queue.sv
// ---------------------------------------------------------------------------
// reg_write_queue
//
// Write-back queue in front of the 32x32 register file. It collects write
// requests from two producers, which are the ALU result path and the
// load/multi-cycle result path. The requests are held in a small in-order
// FIFO, and one write per cycle is drained onto the register file port
// (o_wr/o_wa/o_wd). The queue also provides a newest-match read bypass on
// two lookup addresses, so that decode can see values that are still queued.
//
// Optional feature (compile-time macro ZERO_REG_DROP_EN):
//   defined   : requests to register 0 are discarded at the input. They do
//               not set overflow. Lookups of register 0 never hit.
//   undefined : register 0 is treated like any other register.
//
// Ports:
//   i_clk          clock; all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_alu_wr/wa/wd ALU write request, destination and data
//   i_ld_wr/wa/wd  load write request, destination and data
//   o_stall        producers must not push while high
//   o_overflow     sticky; set when a push was dropped
//   o_count        number of occupied entries
//   o_wr/wa/wd     register file write port (head of the queue)
//   i_ra/i_rb      bypass lookup addresses
//   o_hit_a/b      lookup matches a queued entry
//   o_fwd_a/b      data of the youngest matching entry (0 when no hit)
// ---------------------------------------------------------------------------
module reg_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_alu_wr,
    input  logic [AW-1:0]          i_alu_wa,
    input  logic [DW-1:0]          i_alu_wd,
    input  logic                   i_ld_wr,
    input  logic [AW-1:0]          i_ld_wa,
    input  logic [DW-1:0]          i_ld_wd,
    output logic                   o_stall,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_wr,
    output logic [AW-1:0]          o_wa,
    output logic [DW-1:0]          o_wd,
    input  logic [AW-1:0]          i_ra,
    input  logic [AW-1:0]          i_rb,
    output logic                   o_hit_a,
    output logic                   o_hit_b,
    output logic [DW-1:0]          o_fwd_a,
    output logic [DW-1:0]          o_fwd_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];

    logic          w_pop;
    logic [CW:0]   w_free;
    logic          w_alu_req;
    logic          w_ld_req;
    logic          w_alu_acc;
    logic          w_ld_acc;
    logic          w_drop;
    logic [CW-1:0] w_n_acc;
    logic [PW-1:0] w_ld_slot;

    // The register file always accepts, so a non-empty queue pops every edge.
    assign w_pop = (r_count != '0);

`ifdef ZERO_REG_DROP_EN
    assign w_alu_req = i_alu_wr && (i_alu_wa != '0);
    assign w_ld_req  = i_ld_wr  && (i_ld_wa  != '0);
`else
    assign w_alu_req = i_alu_wr;
    assign w_ld_req  = i_ld_wr;
`endif

    // The slot freed by this edge's pop can be reused by this edge's push.
    assign w_free    = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);
    assign w_alu_acc = w_alu_req && (w_free != '0);
    assign w_ld_acc  = w_ld_req  && (w_free > (CW+1)'(w_alu_acc));
    assign w_drop    = (w_alu_req && !w_alu_acc) || (w_ld_req && !w_ld_acc);
    assign w_n_acc   = CW'(w_alu_acc) + CW'(w_ld_acc);
    // The load entry is younger, so it goes behind the ALU entry when both are accepted.
    assign w_ld_slot = r_tail + PW'(w_alu_acc);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_n_acc);
            r_count <= r_count + w_n_acc - CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage is not reset; validity comes from head/count only.
    always_ff @(posedge i_clk) begin
        if (w_alu_acc) begin
            r_addr[r_tail] <= i_alu_wa;
            r_data[r_tail] <= i_alu_wd;
        end
        if (w_ld_acc) begin
            r_addr[w_ld_slot] <= i_ld_wa;
            r_data[w_ld_slot] <= i_ld_wd;
        end
    end

    assign o_wr       = w_pop;
    assign o_wa       = r_addr[r_head];
    assign o_wd       = r_data[r_head];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_stall    = (r_count >= CW'(DEPTH - 1));

    // Bypass search. Slot gi is the gi-th oldest entry, counted from the head.
    logic [PW-1:0]    w_slot [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_match_a;
    logic [DEPTH-1:0] w_match_b;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign w_slot[gi]  = r_head + PW'(gi);
        assign w_valid[gi] = (CW'(gi) < r_count);
`ifdef ZERO_REG_DROP_EN
        assign w_match_a[gi] = w_valid[gi] && (i_ra != '0) && (r_addr[w_slot[gi]] == i_ra);
        assign w_match_b[gi] = w_valid[gi] && (i_rb != '0) && (r_addr[w_slot[gi]] == i_rb);
`else
        assign w_match_a[gi] = w_valid[gi] && (r_addr[w_slot[gi]] == i_ra);
        assign w_match_b[gi] = w_valid[gi] && (r_addr[w_slot[gi]] == i_rb);
`endif
    end

    // Scanning oldest to youngest lets the youngest match win.
    always_comb begin
        o_hit_a = |w_match_a;
        o_hit_b = |w_match_b;
        o_fwd_a = '0;
        o_fwd_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match_a[k]) o_fwd_a = r_data[w_slot[k]];
            if (w_match_b[k]) o_fwd_b = r_data[w_slot[k]];
        end
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// ---------------------------------------------------------------------------
// Testbench for reg_write_queue. A queue-based reference model is compared
// against the DUT outputs on every cycle. Directed literal checks pin down
// the model itself.
// ---------------------------------------------------------------------------
module tb_reg_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          alu_wr;
    logic [AW-1:0] alu_wa;
    logic [DW-1:0] alu_wd;
    logic          ld_wr;
    logic [AW-1:0] ld_wa;
    logic [DW-1:0] ld_wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          stall;
    logic          overflow;
    logic [CW-1:0] count;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          hit_a;
    logic          hit_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    reg_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_alu_wr  (alu_wr),
        .i_alu_wa  (alu_wa),
        .i_alu_wd  (alu_wd),
        .i_ld_wr   (ld_wr),
        .i_ld_wa   (ld_wa),
        .i_ld_wd   (ld_wd),
        .o_stall   (stall),
        .o_overflow(overflow),
        .o_count   (count),
        .o_wr      (wr),
        .o_wa      (wa),
        .o_wd      (wd),
        .i_ra      (ra),
        .i_rb      (rb),
        .o_hit_a   (hit_a),
        .o_hit_b   (hit_b),
        .o_fwd_a   (fwd_a),
        .o_fwd_b   (fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    int   n_tests;
    int   n_fail;
    int   cyc;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit req_ok(input logic v, input logic [AW-1:0] a);
`ifdef ZERO_REG_DROP_EN
        return v && (a != 0);
`else
        return v;
`endif
    endfunction

    // One register file write per edge from a non-empty queue. After that,
    // the ALU request is pushed before the load request, and each is kept
    // only if the queue has room.
    task automatic model_update();
        ent_t e;
        if (mq.size() > 0) void'(mq.pop_front());
        if (req_ok(alu_wr, alu_wa)) begin
            if (mq.size() < DEPTH) begin
                e.a = alu_wa; e.d = alu_wd; mq.push_back(e);
            end else m_ovf = 1;
        end
        if (req_ok(ld_wr, ld_wa)) begin
            if (mq.size() < DEPTH) begin
                e.a = ld_wa; e.d = ld_wd; mq.push_back(e);
            end else m_ovf = 1;
        end
    endtask

    task automatic lookup(input logic [AW-1:0] addr, output logic h, output logic [DW-1:0] f);
        h = 0;
        f = '0;
`ifdef ZERO_REG_DROP_EN
        if (addr == 0) return;
`endif
        foreach (mq[i]) begin
            if (mq[i].a == addr) begin
                h = 1;
                f = mq[i].d;
            end
        end
    endtask

    // Compares every DUT output against the model for the current cycle.
    task automatic compare_all();
        logic          h;
        logic [DW-1:0] f;
        check("wr", DW'(wr), DW'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("wa", DW'(wa), DW'(mq[0].a));
            check("wd", wd, mq[0].d);
        end
        check("count", DW'(count), DW'(mq.size()));
        check("stall", DW'(stall), DW'(mq.size() >= DEPTH - 1));
        check("overflow", DW'(overflow), DW'(m_ovf));
        lookup(ra, h, f);
        check("hit_a", DW'(hit_a), DW'(h));
        check("fwd_a", fwd_a, f);
        lookup(rb, h, f);
        check("hit_b", DW'(hit_b), DW'(h));
        check("fwd_b", fwd_b, f);
    endtask

    task automatic set_idle();
        alu_wr = 0; alu_wa = '0; alu_wd = '0;
        ld_wr  = 0; ld_wa  = '0; ld_wd  = '0;
    endtask

    // Inputs are applied at the falling edge. The model advances at the
    // rising edge. The comparison runs at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
        cyc++;
        $display("[TB] cyc %0d alu=%0b/%0d ld=%0b/%0d -> wr=%0b wa=%0d wd=%0h cnt=%0d",
                 cyc, alu_wr, alu_wa, ld_wr, ld_wa, wr, wa, wd, count);
        compare_all();
    endtask

    task automatic async_reset();
        #1 rst_n = 0;
        #1;
        check("rst_async_wr", DW'(wr), 0);
        check("rst_async_count", DW'(count), 0);
        check("rst_async_hit_a", DW'(hit_a), 0);
        mq.delete();
        m_ovf = 0;
        compare_all();
        set_idle();
        tick();
        rst_n = 1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; m_ovf = 0;
        rst_n = 0; ra = '0; rb = '0;
        set_idle();
        #12;
        check("reset_wr", DW'(wr), 0);
        check("reset_count", DW'(count), 0);
        check("reset_overflow", DW'(overflow), 0);
        check("reset_hit_a", DW'(hit_a), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Single push.
        alu_wr = 1; alu_wa = 5'd5; alu_wd = 32'h1234;
        tick();
        check("single_wr", DW'(wr), 1);
        check("single_wa", DW'(wa), 5);
        check("single_wd", wd, 32'h1234);
        check("single_count", DW'(count), 1);
        set_idle();
        tick();
        check("single_wr_off", DW'(wr), 0);
        check("single_count_off", DW'(count), 0);

        // Dual push to the same register. The younger entry wins the bypass.
        ra = 5'd3;
        alu_wr = 1; alu_wa = 5'd3; alu_wd = 32'hAAAA;
        ld_wr  = 1; ld_wa  = 5'd3; ld_wd  = 32'hBBBB;
        tick();
        check("dual_hit_a", DW'(hit_a), 1);
        check("dual_fwd_a", fwd_a, 32'hBBBB);
        check("dual_wd0", wd, 32'hAAAA);
        set_idle();
        tick();
        check("dual_wd1", wd, 32'hBBBB);
        check("dual_wr1", DW'(wr), 1);
        tick();
        check("dual_empty", DW'(wr), 0);

        // Pushing two requests per cycle fills the queue and then overflows.
        ra = 5'd0;
        for (int i = 0; i < 4; i++) begin
            alu_wr = 1; alu_wa = 5'(8 + 2*i); alu_wd = 32'(100 + 2*i);
            ld_wr  = 1; ld_wa  = 5'(9 + 2*i); ld_wd  = 32'(101 + 2*i);
            tick();
            if (i == 1) begin
                check("ovf_stall_at3", DW'(stall), 1);
                check("ovf_count3", DW'(count), 3);
                check("ovf_not_yet", DW'(overflow), 0);
            end
            if (i == 3) begin
                check("ovf_set", DW'(overflow), 1);
                check("ovf_count4", DW'(count), 4);
            end
        end
        set_idle();
        for (int i = 0; i < 5; i++) tick();
        check("ovf_sticky", DW'(overflow), 1);

        // Asynchronous reset while three entries are queued.
        alu_wr = 1; alu_wa = 5'd7; alu_wd = 32'h77;
        ld_wr  = 1; ld_wa  = 5'd6; ld_wd  = 32'h66;
        tick();
        tick();
        check("pre_rst_count", DW'(count), 3);
        ra = 5'd7;
        set_idle();
        async_reset();
        check("post_rst_ovf", DW'(overflow), 0);
        alu_wr = 1; alu_wa = 5'd4; alu_wd = 32'h44;
        tick();
        check("post_rst_wr", DW'(wr), 1);
        check("post_rst_wd", wd, 32'h44);
        set_idle();
        tick();

        // Sequential single writes wrap the pointers.
        for (int i = 1; i <= 10; i++) begin
            alu_wr = 1; alu_wa = 5'(i); alu_wd = 32'(i * 32'h11);
            tick();
            check("wrap_wa", DW'(wa), DW'(i));
            check("wrap_wd", wd, 32'(i * 32'h11));
            check("wrap_count", DW'(count), 1);
        end
        set_idle();
        tick();

`ifdef ZERO_REG_DROP_EN
        ra = 5'd0;
        alu_wr = 1; alu_wa = 5'd0; alu_wd = 32'hFFFF;
        tick();
        check("zero_wr", DW'(wr), 0);
        check("zero_count", DW'(count), 0);
        check("zero_hit_a", DW'(hit_a), 0);
        set_idle();
        tick();
`endif

        // Randomized traffic. Stall is usually honoured and sometimes ignored.
        for (int i = 0; i < 400; i++) begin
            bit obey;
            obey   = ($urandom_range(0, 9) != 0);
            alu_wr = ($urandom_range(0, 1) == 1) && !(obey && stall);
            ld_wr  = ($urandom_range(0, 2) == 0) && !(obey && stall);
            alu_wa = 5'($urandom_range(0, 7));
            ld_wa  = 5'($urandom_range(0, 7));
            alu_wd = $urandom;
            ld_wd  = $urandom;
            ra     = 5'($urandom_range(0, 7));
            rb     = 5'($urandom_range(0, 7));
            tick();
            if (i == 200) begin
                set_idle();
                async_reset();
            end
        end
        set_idle();
        for (int i = 0; i < 6; i++) tick();
        check("final_empty", DW'(count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
- Writer-side companion to the 32x32 register file.
- Collects write-back requests from two producers: the ALU result path and the load/multi-cycle result path.
- Buffers the requests in a small in-order FIFO and drains one write per cycle onto the register file's WR/WA/WD port.
- Provides newest-match read bypass on two read addresses, so decode sees values still queued.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
AW, 5, register address width
DW, 32, register data width

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset  input  1  asynchronous, active-low reset
AluWr  input  1  ALU write request
AluWA  input  AW  ALU destination register
AluWD  input  DW  ALU result
LdWr  input  1  load/multi-cycle write request
LdWA  input  AW  load destination register
LdWD  input  DW  load data
Stall  output  1  producers must not push while high
Overflow  output  1  sticky; a push was dropped
Count  output  $clog2(DEPTH)+1  occupied entries
WR  output  1  register file write enable
WA  output  AW  register file write address
WD  output  DW  register file write data
RA  input  AW  bypass lookup address A
RB  input  AW  bypass lookup address B
HitA  output  1  RA matches a queued entry
HitB  output  1  RB matches a queued entry
FwdA  output  DW  newest queued data for RA
FwdB  output  DW  newest queued data for RB

Behaviour:
- Reset low (asynchronous) clears:
  - head, tail, Count and Overflow to 0;
  - WR, HitA and HitB to 0 immediately.
- Entry contents are not cleared; they are don't-care while invalid.
- Drain:
  - WR = (Count != 0), combinational. WA/WD are the head entry.
  - The register file always accepts, so the head pops on every edge where WR = 1.
- Latency: a request pushed at edge N drives WR in the cycle following edge N, when the queue was empty.
- Push order within one cycle: the ALU entry is enqueued first (older), then the load entry. Each valid request occupies one slot.
- Capacity for one edge: free = DEPTH - Count + pop.
  - Accept requests in ALU-then-load order while free slots remain.
  - Any excess request is dropped, and Overflow sets (stays set until reset).
- Stall = (Count >= DEPTH-1), registered-state-derived. This guarantees 2 pushes are legal whenever Stall = 0.
- Count_next = Count + accepted - pop. Pointers are log2(DEPTH)-bit and wrap modulo DEPTH.
- Bypass, combinational over valid entries only:
  - HitA = 1 if any valid entry has addr == RA. FwdA = data of the youngest such entry; FwdA = 0 when no hit.
  - Same rules for B.
  - The head entry being drained this cycle still counts as valid.
  - Same-cycle incoming requests are not searched.
- Duplicate addresses are kept in order; the youngest wins for bypass, and the drain writes all of them in order.
- Simultaneous full drain and two pushes at Count = DEPTH-1: this is a legal sequence only if Stall was honoured; the accounting formula above applies regardless.

Optional Feature:
- Macro ZERO_REG_DROP_EN.
  - Defined: requests with address 0 are discarded at input. They are not enqueued and do not set Overflow. RA/RB = 0 never hit, and FwdA/FwdB = 0.
  - Undefined: address 0 is treated like any other register.

Test Plan:
- Reset mid-operation: 3 entries queued, Reset low asynchronously -> WR, Count and HitA go to 0 without a clock edge. After release, the queue is empty and the first new push appears on WR one cycle later.
- Single push, AluWr = 1, AluWA = 5, AluWD = 0x1234 -> next cycle WR = 1, WA = 5, WD = 0x1234, Count = 1. The following cycle WR = 0, Count = 0.
- Dual push, ALU (3, 0xAAAA) and load (3, 0xBBBB) in the same cycle, RA = 3:
  - next cycle HitA = 1, FwdA = 0xBBBB;
  - the drain writes 0xAAAA then 0xBBBB on consecutive cycles.
- Stall/overflow with DEPTH = 4, drain blocked conceptually by pushing 2 per cycle:
  - Stall rises at Count = 3.
  - Forcing a push that exceeds capacity -> the load request is dropped, Overflow = 1 and stays high; the ALU request is still accepted if a slot was free.
- Wrap-around: push 10 sequential single writes to addresses 1..10 with data = address*0x11 -> WR sequence matches exactly in order, and Count never exceeds 1.
- ZERO_REG_DROP_EN defined: AluWr to address 0 with 0xFFFF -> no WR pulse, Count stays 0, RA = 0 gives HitA = 0.
